stomach: RTL and testbench

STOMACH -- requirements
Module: stomach

---
 rtl/stomach_if.sv | 23 ++
 rtl/stomach.sv | 96 +++++++++
 tb/tb_stomach.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/stomach_if.sv
// Request bus from the scratchpad bank arbiter into one stomach stage.
// The master drives a word access; the slave answers with req_ready.
interface stomach_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 128
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic              req_src;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;

  modport master (
    output req_valid, req_write, req_src, req_addr, req_wdata,
    input  req_ready
  );

  modport slave (
    input  req_valid, req_write, req_src, req_addr, req_wdata,
    output req_ready
  );
endinterface

// File: rtl/stomach.sv
// Scratchpad bank stage: issues accepted requests to the SRAM macro and
// tracks their metadata through a fixed-latency pipe into an ordered result register.
module stomach #(
  parameter logic [1:0] IDX    = '0,
  parameter int         RD_LAT = 2,
  parameter int         ADDR_W = 10,
  parameter int         DATA_W = 128
) (
  input  logic              clk,
  input  logic              rst,
  stomach_if.slave          req,
  input  logic              sram_gnt,
  output logic              sram_en,
  output logic              sram_we,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata,
  output logic              res_valid,
  output logic              res_write,
  output logic              res_src,
  output logic [DATA_W-1:0] res_rdata,
  output logic [2:0]        inflight_cnt,
  output logic              idle
);

  if (RD_LAT < 1 || RD_LAT > 4) begin : g_bad_rd_lat
    $error("stomach[%0d]: RD_LAT must be 1..4", IDX);
  end

  logic              accept;
  logic [RD_LAT-1:0] meta_v;
  logic [RD_LAT-1:0] meta_w;
  logic [RD_LAT-1:0] meta_s;
  logic              retire_v;
  logic              retire_w;
  logic              retire_s;

  assign req.req_ready = sram_gnt && !rst;
  assign accept        = req.req_valid && req.req_ready;

  always_comb begin
    sram_en    = accept;
    sram_we    = accept && req.req_write;
    sram_addr  = req.req_addr;
    sram_wdata = req.req_wdata;
  end

  // The tail stage never stalls, so the metadata pipe shifts every cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_v <= '0;
      meta_w <= '0;
      meta_s <= '0;
    end else begin
      meta_v[0] <= accept;
      meta_w[0] <= accept && req.req_write;
      meta_s[0] <= accept && req.req_src;
      for (int i = 1; i < RD_LAT; i++) begin
        meta_v[i] <= meta_v[i-1];
        meta_w[i] <= meta_w[i-1];
        meta_s[i] <= meta_s[i-1];
      end
    end
  end

  assign retire_v = meta_v[RD_LAT-1];
  assign retire_w = meta_w[RD_LAT-1];
  assign retire_s = meta_s[RD_LAT-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      res_valid <= 1'b0;
      res_write <= 1'b0;
      res_src   <= 1'b0;
      res_rdata <= '0;
    end else begin
      res_valid <= retire_v;
      res_write <= retire_v && retire_w;
      res_src   <= retire_v && retire_s;
      res_rdata <= (retire_v && !retire_w) ? sram_rdata : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      inflight_cnt <= '0;
    end else if (accept && !retire_v) begin
      inflight_cnt <= inflight_cnt + 3'd1;
    end else if (!accept && retire_v) begin
      inflight_cnt <= inflight_cnt - 3'd1;
    end
  end

  assign idle = (inflight_cnt == 3'd0) && !res_valid;

endmodule

// File: tb/tb_stomach.sv
// Bench for stomach: a small SRAM model answers accesses, and a scoreboard
// queue predicts each result's contents and arrival cycle.
module tb_stomach;
  localparam int   RD_LAT = 2;
  localparam int   ADDR_W = 10;
  localparam int   DATA_W = 128;
  localparam logic SRC_FE = 1'b0;
  localparam logic SRC_BE = 1'b1;

  typedef struct {
    logic              write;
    logic              src;
    logic [DATA_W-1:0] rdata;
    int                due;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              sram_gnt = 1'b0;
  logic              sram_en;
  logic              sram_we;
  logic [ADDR_W-1:0] sram_addr;
  logic [DATA_W-1:0] sram_wdata;
  logic [DATA_W-1:0] sram_rdata;
  logic              res_valid;
  logic              res_write;
  logic              res_src;
  logic [DATA_W-1:0] res_rdata;
  logic [2:0]        inflight_cnt;
  logic              idle;

  stomach_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  stomach #(
    .IDX(2'd1), .RD_LAT(RD_LAT), .ADDR_W(ADDR_W), .DATA_W(DATA_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req          (bus),
    .sram_gnt     (sram_gnt),
    .sram_en      (sram_en),
    .sram_we      (sram_we),
    .sram_addr    (sram_addr),
    .sram_wdata   (sram_wdata),
    .sram_rdata   (sram_rdata),
    .res_valid    (res_valid),
    .res_write    (res_write),
    .res_src      (res_src),
    .res_rdata    (res_rdata),
    .inflight_cnt (inflight_cnt),
    .idle         (idle)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // SRAM macro model: read data appears RD_LAT cycles after the access cycle.
  logic [DATA_W-1:0] mem  [1024];
  logic [DATA_W-1:0] pipe [RD_LAT];

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 1024; i++) mem[i] <= {4{32'(i) * 32'h9E3779B1}};
      mem[16] <= 128'hA5A5;
    end else if (sram_en && sram_we) begin
      mem[sram_addr] <= sram_wdata;
    end
    pipe[0] <= (sram_en && !sram_we) ? mem[sram_addr]
                                     : {$urandom(), $urandom(), $urandom(), $urandom()};
    for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
  end

  assign sram_rdata = pipe[RD_LAT-1];

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [DATA_W-1:0] got,
                     input logic [DATA_W-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  exp_t q[$];
  bit   armed = 1'b0;

  always @(negedge clk) begin
    if (armed) begin : mon
      exp_t e;
      logic ev;
      logic acc;
      ev = 1'b0;
      if (q.size() > 0) ev = (q[0].due == cyc);
      chk("res_valid", DATA_W'(res_valid), DATA_W'(ev));
      if (ev) begin
        e = q.pop_front();
        chk("res_write", DATA_W'(res_write), DATA_W'(e.write));
        chk("res_src",   DATA_W'(res_src),   DATA_W'(e.src));
        chk("res_rdata", res_rdata, e.rdata);
      end else begin
        chk("idle_res_write", DATA_W'(res_write), '0);
        chk("idle_res_src",   DATA_W'(res_src),   '0);
        chk("idle_res_rdata", res_rdata,          '0);
      end
      chk("inflight_cnt", DATA_W'(inflight_cnt), DATA_W'(q.size()));
      chk("idle", DATA_W'(idle), DATA_W'((q.size() == 0) && !ev));
      acc = bus.req_valid && sram_gnt && !rst;
      chk("req_ready", DATA_W'(bus.req_ready), DATA_W'(sram_gnt && !rst));
      chk("sram_en",   DATA_W'(sram_en),       DATA_W'(acc));
      chk("sram_we",   DATA_W'(sram_we),       DATA_W'(acc && bus.req_write));
      if (acc) begin
        chk("sram_addr",  DATA_W'(sram_addr), DATA_W'(bus.req_addr));
        chk("sram_wdata", sram_wdata,         bus.req_wdata);
      end
      if (rst) begin
        q.delete();
      end else if (acc) begin
        e.write = bus.req_write;
        e.src   = bus.req_src;
        e.rdata = bus.req_write ? '0 : mem[bus.req_addr];
        e.due   = cyc + RD_LAT + 1;
        q.push_back(e);
      end
    end
  end

  task automatic step(input logic v, input logic w, input logic s,
                      input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                      input logic g, input logic r);
    bus.req_valid = v;
    bus.req_write = w;
    bus.req_src   = s;
    bus.req_addr  = a;
    bus.req_wdata = d;
    sram_gnt      = g;
    rst           = r;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0);
  endtask

  function automatic logic [DATA_W-1:0] rnd_data();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_src   = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    sram_gnt      = 1'b1;
    rst           = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst   = 1'b0;
    armed = 1'b1;
    idle_cycles(3);

    // single read of the preloaded word
    step(1'b1, 1'b0, SRC_FE, 10'h010, rnd_data(), 1'b1, 1'b0);
    idle_cycles(4);

    // write ack, then read the written word back
    step(1'b1, 1'b1, SRC_BE, 10'h020, 128'hDEAD_BEEF_0123_4567_89AB_CDEF_1357_9BDF, 1'b1, 1'b0);
    idle_cycles(4);
    step(1'b1, 1'b0, SRC_FE, 10'h020, rnd_data(), 1'b1, 1'b0);
    idle_cycles(4);

    // eight back-to-back accepts, alternating requester
    for (int i = 0; i < 8; i++)
      step(1'b1, (i == 3 || i == 6), 1'(i), 10'(i + 4), rnd_data(), 1'b1, 1'b0);
    idle_cycles(5);

    // grant stall while the previous access keeps retiring
    step(1'b1, 1'b0, SRC_FE, 10'h005, rnd_data(), 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, SRC_BE, 10'h007, rnd_data(), 1'b0, 1'b0);
    step(1'b1, 1'b0, SRC_BE, 10'h007, rnd_data(), 1'b1, 1'b0);
    idle_cycles(4);

    // random traffic with grant gaps
    for (int i = 0; i < 300; i++)
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           10'($urandom_range(0, 31)), rnd_data(), ($urandom_range(0, 3) != 0), 1'b0);
    idle_cycles(5);

    // reset with two accesses in flight, request still presented during reset
    step(1'b1, 1'b0, SRC_FE, 10'h003, rnd_data(), 1'b1, 1'b0);
    step(1'b1, 1'b1, SRC_BE, 10'h004, rnd_data(), 1'b1, 1'b0);
    step(1'b1, 1'b0, SRC_FE, 10'h005, rnd_data(), 1'b1, 1'b1);
    idle_cycles(5);

    // back-to-back after reset
    for (int i = 0; i < 4; i++)
      step(1'b1, 1'b0, 1'(i), 10'h010, rnd_data(), 1'b1, 1'b0);
    idle_cycles(6);

    chk("drain", DATA_W'(q.size()), '0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
